// File: rtl/nvio_shift_pipe_if.sv
// Operation/result handshake bundle for nvio_shift_pipe.
// The slave side is the shifter; the master side is the producer/consumer.
interface nvio_shift_pipe_if #(
    parameter int WID  = 80,
    parameter int TAGW = 6,
    parameter int AW   = $clog2(WID) + 1
);
    logic            valid_i;
    logic            ready_o;
    logic [2:0]      op_i;
    logic [WID-1:0]  a_i;
    logic [WID-1:0]  c_i;
    logic [AW-1:0]   b_i;
    logic [TAGW-1:0] tag_i;
    logic            valid_o;
    logic            ready_i;
    logic [WID-1:0]  res_o;
    logic            ov_o;
    logic            ill_o;
    logic [TAGW-1:0] tag_o;

    modport master (
        output valid_i, op_i, a_i, c_i, b_i, tag_i, ready_i,
        input  ready_o, valid_o, res_o, ov_o, ill_o, tag_o
    );

    modport slave (
        input  valid_i, op_i, a_i, c_i, b_i, tag_i, ready_i,
        output ready_o, valid_o, res_o, ov_o, ill_o, tag_o
    );
endinterface

// File: rtl/nvio_shift_pipe.sv
// Pipelined shift/rotate/funnel unit. Every op is folded into one right shift of a
// 2*WID-bit word {hi,lo}; the low WID bits of the shifted word are the result.
module nvio_shift_pipe #(
    parameter int WID         = 80,
    parameter int STAGES      = 2,
    parameter int TAGW        = 6,
    parameter bit ROTATE_INSN = 1'b1
) (
    input logic              clk,
    input logic              rst,
    nvio_shift_pipe_if.slave bus
);
    localparam int AW   = $clog2(WID) + 1;
    localparam int DW   = 2 * WID;
    localparam int GRPS = (STAGES > 1) ? STAGES - 1 : 1;
    localparam int LPG  = (AW + GRPS - 1) / GRPS;

    localparam logic [2:0] OP_SHL = 3'd0, OP_ASL = 3'd1, OP_SHR = 3'd2, OP_ASR = 3'd3,
                           OP_ROL = 3'd4, OP_ROR = 3'd5, OP_FSL = 3'd6, OP_FSR = 3'd7;

    typedef struct packed {
        logic [DW-1:0]   dat;
        logic [AW-1:0]   amt;
        logic            ov;
        logic            ill;
        logic [TAGW-1:0] tag;
    } stage_t;

    // Applies the barrel levels [lo_l, hi_l) that belong to one pipeline slice.
    function automatic stage_t shift_lvls(input stage_t s, input int lo_l, input int hi_l);
        stage_t r;
        r = s;
        for (int j = 0; j < AW; j++)
            if (j >= lo_l && j < hi_l && s.amt[j]) r.dat = r.dat >> (1 << j);
        return r;
    endfunction

    logic            en, acc;
    logic [AW-1:0]   n_cl, m_amt, amt;
    logic [WID-1:0]  hi, lo;
    logic            left, ill, ov;
    stage_t          dec;
    stage_t          stg_d [STAGES];
    stage_t          stg_q [STAGES];
    logic [STAGES-1:0] vld_pipe;

    assign en          = ~bus.valid_o | bus.ready_i;
    assign acc         = bus.valid_i & en;
    assign bus.ready_o = en;

    // Left shifts by s become right shifts by WID-s of the same double word.
    always_comb begin
        n_cl  = (bus.b_i >= AW'(WID)) ? AW'(WID) : bus.b_i;
        m_amt = bus.b_i % AW'(WID);
        hi    = '0;
        lo    = bus.a_i;
        amt   = n_cl;
        left  = 1'b0;
        ill   = ~ROTATE_INSN & bus.op_i[2];
        ov    = 1'b0;
        case (bus.op_i)
            OP_SHL, OP_ASL: begin hi = bus.a_i; lo = '0; left = 1'b1; end
            OP_SHR: ;
            OP_ASR: hi = {WID{bus.a_i[WID-1]}};
            OP_ROL: begin hi = bus.a_i; amt = m_amt; left = 1'b1; end
            OP_ROR: begin hi = bus.a_i; amt = m_amt; end
            OP_FSL: begin hi = bus.a_i; lo = bus.c_i; amt = m_amt; left = 1'b1; end
            OP_FSR: begin hi = bus.a_i; lo = (m_amt == '0) ? bus.a_i : bus.c_i; amt = m_amt; end
            default: ;
        endcase
        // ASL overflows unless the top n+1 bits of a all match the sign.
        if (bus.op_i == OP_ASL) begin
            if (bus.b_i >= AW'(WID)) ov = |bus.a_i;
            else
                for (int i = 0; i < WID - 1; i++)
                    if (i + int'(bus.b_i) >= WID - 1 && bus.a_i[i] != bus.a_i[WID-1]) ov = 1'b1;
        end
        if (ill) begin
            hi   = '0;
            lo   = '0;
            amt  = '0;
            left = 1'b0;
        end
        dec.dat = {hi, lo};
        dec.amt = left ? AW'(WID) - amt : amt;
        dec.ov  = ov;
        dec.ill = ill;
        dec.tag = bus.tag_i;
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            if (k == 0)
                stg_d[k] = (STAGES == 1) ? shift_lvls(dec, 0, AW) : dec;
            else
                stg_d[k] = shift_lvls(stg_q[(k > 0) ? k - 1 : 0], (k - 1) * LPG,
                                      (k == STAGES - 1) ? AW : k * LPG);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe <= '0;
            for (int k = 0; k < STAGES; k++) stg_q[k] <= '0;
        end else if (en) begin
            vld_pipe <= STAGES'({vld_pipe, acc});
            for (int k = 0; k < STAGES; k++) stg_q[k] <= stg_d[k];
        end
    end

    assign bus.valid_o = vld_pipe[STAGES-1];
    assign bus.res_o   = stg_q[STAGES-1].dat[WID-1:0];
    assign bus.ov_o    = stg_q[STAGES-1].ov;
    assign bus.ill_o   = stg_q[STAGES-1].ill;
    assign bus.tag_o   = stg_q[STAGES-1].tag;
endmodule
